inst_rom_loader: RTL and testbench
==================================

# inst_rom_loader

Instruction-memory responder for the OpenMIPS core's fetch port, plus a byte-serial program loader. It answers every `rom_ce`/`rom_addr` fetch with the addressed 32-bit word in the same cycle; the core has no stall input, so zero-latency reads are mandatory. A valid/ready byte stream can reload the program image, during which the block holds the core in reset and returns NOPs. It sits beside the core in the SoC top level, driving the core's `rom_data_i` and `rst`.

## Interface
Parameters:
- `ADDR_W`, 10: word-address width; memory depth is 2^ADDR_W 32-bit words.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ce`  in  1  fetch enable from the core's `rom_ce_o`.
- `addr`  in  32  byte fetch address from the core's `rom_addr_o`.
- `inst_o`  out  32  fetched instruction, to the core's `rom_data_i`.
- `ld_start`  in  1  request a new program load.
- `ld_valid`  in  1  `ld_byte` is valid.
- `ld_byte`  in  8  program byte; big-endian order (the first byte of each word is bits 31:24).
- `ld_last`  in  1  marks the final byte of the image; qualified by `ld_valid`.
- `ld_ready`  out  1  loader accepts a byte this cycle.
- `cpu_rst_o`  out  1  reset to the core.
- `busy`  out  1  a load is in progress.
- `done`  out  1  one-cycle pulse when a load completes.
- `err`  out  1  sticky overflow flag; the image exceeded the memory depth.
- `words_o`  out  ADDR_W+1  number of words written by the last load.

## Operation
- Fetch path (combinational):
  - When `ce`=1 and state=IDLE: `inst_o` = mem[`addr`[ADDR_W+1:2]].
  - Otherwise `inst_o` = 0 (NOP).
  - `addr`[1:0] is ignored. Upper address bits are ignored, so fetches alias modulo the depth.
- States: IDLE, LOAD, DRAIN, FINISH.
- IDLE:
  - `ld_ready`=0.
  - `ld_start`=1 moves to LOAD and clears the write pointer, byte count, `words_o` and `err`.
- LOAD:
  - `ld_ready`=1. A byte is accepted when `ld_valid` and `ld_ready` are both 1.
  - The byte is shifted into a 32-bit assembly register at lane (3 − byte count).
  - On the 4th byte, the assembled word is written to mem[wptr], wptr increments and `words_o` increments.
  - If accepted byte has `ld_last`=1:
    - Unfilled lanes of a partial word are written as 0.
    - The word is still written (if at least one byte is pending).
    - Next state is FINISH.
  - If a word write fills address 2^ADDR_W−1 and `ld_last` is 0: next state is DRAIN.
- DRAIN:
  - `ld_ready`=1. Accepted bytes are discarded and nothing is written.
  - The first accepted byte sets `err`.
  - Accepting `ld_last` moves to FINISH.
- FINISH: lasts one cycle, asserts `done`, then returns to IDLE.
- `ld_start` outside IDLE is ignored.
- `cpu_rst_o` = `rst` OR (state ≠ IDLE).
- `busy` = (state ≠ IDLE).
- Memory contents are not cleared by reset. After reset, contents stay undefined until the first load.
- Reset mid-load: state goes to IDLE and wptr and the assembly register are cleared. Words already written remain in memory. `err` is cleared. `done` is not pulsed.
- A 1024-word image exactly fits, with `ld_last` on byte 4096: no DRAIN, `err`=0, `words_o`=1024.

## Timing
- Reset values: state=IDLE, `ld_ready`=0, `busy`=0, `done`=0, `err`=0, `words_o`=0, `cpu_rst_o`=1 while `rst`=1.
- Fetch latency is 0 cycles; `inst_o` follows `addr` combinationally.
- `ld_start` sampled high at edge N: `busy`, `cpu_rst_o` and `ld_ready` are high from cycle N+1.
- A word write completes at the edge that accepts its 4th byte (or its `ld_last` byte). It is visible on `inst_o` from the next cycle once in IDLE.
- The edge that accepts `ld_last` moves the block to FINISH: `done`=1 for that one cycle. The block returns to IDLE at the following edge, and `cpu_rst_o` falls then.
- Throughput is 1 byte per cycle. `ld_valid` may deassert at any time with no penalty.

## Test plan
- Reset, then fetch with `ce`=0 → `inst_o`=0, `cpu_rst_o`=1 during reset and 0 after.
- Load bytes 24 02 00 05 3C 03 12 34 (`ld_last` on 8th byte), then fetch `addr`=0x0 and 0x4 → 0x24020005 and 0x3C031234. Required: `words_o`=2, `done` pulses once, `busy` high for exactly 9 cycles.
- Load 5 bytes AA BB CC DD EE (last on EE) → mem[1]=0xEE000000, `words_o`=2.
- `ADDR_W`=2, stream 20 bytes with last on the 20th → mem[0..3] hold bytes 1–16; bytes 17–20 are discarded. Required: `err`=1, `words_o`=4; a fetch of `addr`=0x10 aliases to mem[0].
- Interleave gaps in `ld_valid`, and assert `ld_start` mid-load → bytes are assembled correctly and the second `ld_start` has no effect.
- Assert `rst` after 6 bytes → state IDLE, `done` never pulses, mem[0] retains its word, and the next load starts at wptr=0.

Source files
------------

// File: rtl/inst_rom_loader.sv
// ============================================================================
// Module      : inst_rom_loader
// Description : Zero-latency instruction ROM for the OpenMIPS fetch port with
//               a byte-serial, big-endian program loader that holds the core
//               in reset while a new image is written.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_rom_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [31:0]       addr,
    output logic [31:0]       inst_o,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              cpu_rst_o,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_o
);

    localparam int c_DEPTH = 1 << ADDR_W;

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_LOAD   = 2'd1;
    localparam logic [1:0] c_S_DRAIN  = 2'd2;
    localparam logic [1:0] c_S_FINISH = 2'd3;

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = '1;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_wptr;
    logic [1:0]        r_bcnt;
    logic [31:0]       r_asm;
    logic [ADDR_W:0]   r_words;
    logic              r_err;
    logic [31:0]       r_mem [0:c_DEPTH-1];

    logic [31:0]       w_asm_next;
    logic              w_word_done;
    logic              w_we;
    logic              w_addr_unused;

    // Lanes not yet filled stay zero, so a short final word is zero-padded.
    always_comb begin
        w_asm_next = r_asm;
        case (r_bcnt)
            2'd0:    w_asm_next[31:24] = ld_byte;
            2'd1:    w_asm_next[23:16] = ld_byte;
            2'd2:    w_asm_next[15:8]  = ld_byte;
            default: w_asm_next[7:0]   = ld_byte;
        endcase
    end

    assign w_word_done = (r_bcnt == 2'd3) || ld_last;
    assign w_we        = !rst && (r_state == c_S_LOAD) && ld_valid && w_word_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_wptr  <= '0;
            r_bcnt  <= '0;
            r_asm   <= '0;
            r_words <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (ld_start) begin
                        r_state <= c_S_LOAD;
                        r_wptr  <= '0;
                        r_bcnt  <= '0;
                        r_asm   <= '0;
                        r_words <= '0;
                        r_err   <= 1'b0;
                    end
                end
                c_S_LOAD: begin
                    if (ld_valid) begin
                        if (w_word_done) begin
                            r_wptr  <= r_wptr + 1'b1;
                            r_words <= r_words + 1'b1;
                            r_bcnt  <= '0;
                            r_asm   <= '0;
                            if (ld_last)
                                r_state <= c_S_FINISH;
                            else if (r_wptr == c_LAST_ADDR)
                                r_state <= c_S_DRAIN;
                        end else begin
                            r_asm  <= w_asm_next;
                            r_bcnt <= r_bcnt + 1'b1;
                        end
                    end
                end
                c_S_DRAIN: begin
                    if (ld_valid) begin
                        r_err <= 1'b1;
                        if (ld_last)
                            r_state <= c_S_FINISH;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    // Storage is deliberately not reset; contents persist across resets.
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[r_wptr] <= w_asm_next;
    end

    assign inst_o    = (ce && (r_state == c_S_IDLE)) ? r_mem[addr[ADDR_W+1:2]] : 32'd0;
    assign ld_ready  = (r_state == c_S_LOAD) || (r_state == c_S_DRAIN);
    assign busy      = (r_state != c_S_IDLE);
    assign done      = (r_state == c_S_FINISH);
    assign cpu_rst_o = rst || busy;
    assign err       = r_err;
    assign words_o   = r_words;

    assign w_addr_unused = &{1'b0, addr[31:ADDR_W+2], addr[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_inst_rom_loader.sv
// ============================================================================
// Module      : tb_inst_rom_loader
// Description : Directed bench for inst_rom_loader (ADDR_W=10 and ADDR_W=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_rom_loader;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;

    logic        a_ce, a_start, a_valid, a_last;
    logic [31:0] a_addr, a_inst;
    logic [7:0]  a_byte;
    logic        a_ready, a_cpu_rst, a_busy, a_done, a_err;
    logic [10:0] a_words;

    logic        b_ce, b_start, b_valid, b_last;
    logic [31:0] b_addr, b_inst;
    logic [7:0]  b_byte;
    logic        b_ready, b_cpu_rst, b_busy, b_done, b_err;
    logic [2:0]  b_words;

    int          a_busy_cnt = 0;
    int          a_done_cnt = 0;
    int          b_done_cnt = 0;
    int          busy_base, done_base;

    inst_rom_loader #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .ce(a_ce), .addr(a_addr), .inst_o(a_inst),
        .ld_start(a_start), .ld_valid(a_valid), .ld_byte(a_byte), .ld_last(a_last),
        .ld_ready(a_ready), .cpu_rst_o(a_cpu_rst), .busy(a_busy), .done(a_done),
        .err(a_err), .words_o(a_words)
    );

    inst_rom_loader #(.ADDR_W(2)) dut_small (
        .clk(clk), .rst(rst), .ce(b_ce), .addr(b_addr), .inst_o(b_inst),
        .ld_start(b_start), .ld_valid(b_valid), .ld_byte(b_byte), .ld_last(b_last),
        .ld_ready(b_ready), .cpu_rst_o(b_cpu_rst), .busy(b_busy), .done(b_done),
        .err(b_err), .words_o(b_words)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (a_busy) a_busy_cnt++;
        if (a_done) a_done_cnt++;
        if (b_done) b_done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel, input logic [7:0] b, input bit last);
        if (sel) begin b_valid = 1'b1; b_byte = b; b_last = last; end
        else     begin a_valid = 1'b1; a_byte = b; a_last = last; end
        step();
        a_valid = 1'b0; a_last = 1'b0;
        b_valid = 1'b0; b_last = 1'b0;
    endtask

    task automatic start(input bit sel);
        if (sel) b_start = 1'b1; else a_start = 1'b1;
        step();
        a_start = 1'b0; b_start = 1'b0;
    endtask

    task automatic fetch_a(input string tag, input logic [31:0] ad, input logic [31:0] exp);
        a_ce = 1'b1; a_addr = ad;
        #1;
        check(tag, a_inst, exp);
    endtask

    initial begin
        rst = 1'b1;
        a_ce = 1'b0; a_start = 1'b0; a_valid = 1'b0; a_last = 1'b0; a_addr = '0; a_byte = '0;
        b_ce = 1'b0; b_start = 1'b0; b_valid = 1'b0; b_last = 1'b0; b_addr = '0; b_byte = '0;

        // Reset state
        step(); step();
        check("rst_inst",    a_inst, 32'd0);
        check("rst_cpu_rst", a_cpu_rst, 1'b1);
        check("rst_busy",    a_busy, 1'b0);
        check("rst_ready",   a_ready, 1'b0);
        check("rst_done",    a_done, 1'b0);
        check("rst_err",     a_err, 1'b0);
        check("rst_words",   a_words, 11'd0);
        rst = 1'b0;
        step();
        check("post_rst_cpu_rst", a_cpu_rst, 1'b0);

        // Two-word load, busy for exactly 9 cycles
        a_ce = 1'b1; a_addr = 32'h0;
        busy_base = a_busy_cnt; done_base = a_done_cnt;
        start(0);
        check("load_busy",    a_busy, 1'b1);
        check("load_cpu_rst", a_cpu_rst, 1'b1);
        check("load_ready",   a_ready, 1'b1);
        check("load_nop",     a_inst, 32'd0);
        send(0, 8'h24, 0); send(0, 8'h02, 0); send(0, 8'h00, 0); send(0, 8'h05, 0);
        send(0, 8'h3C, 0); send(0, 8'h03, 0); send(0, 8'h12, 0); send(0, 8'h34, 1);
        check("finish_done",  a_done, 1'b1);
        check("finish_cpu_rst", a_cpu_rst, 1'b1);
        step();
        check("idle_done",    a_done, 1'b0);
        check("idle_cpu_rst", a_cpu_rst, 1'b0);
        step();
        check("busy_cycles",  a_busy_cnt - busy_base, 9);
        check("done_pulses",  a_done_cnt - done_base, 1);
        check("words_2",      a_words, 11'd2);
        fetch_a("fetch0", 32'h0, 32'h24020005);
        fetch_a("fetch4", 32'h4, 32'h3C031234);
        a_ce = 1'b0;
        #1 check("ce_off", a_inst, 32'd0);

        // Partial final word zero-padded
        start(0);
        send(0, 8'hAA, 0); send(0, 8'hBB, 0); send(0, 8'hCC, 0); send(0, 8'hDD, 0);
        send(0, 8'hEE, 1);
        step();
        check("partial_words", a_words, 11'd2);
        fetch_a("partial_w0", 32'h0, 32'hAABBCCDD);
        fetch_a("partial_w1", 32'h4, 32'hEE000000);

        // Gaps in ld_valid and an ignored ld_start mid-load
        start(0);
        send(0, 8'h11, 0); step();
        send(0, 8'h22, 0); step(); step();
        a_start = 1'b1;
        send(0, 8'h33, 0);
        a_start = 1'b0;
        send(0, 8'h44, 0); send(0, 8'h55, 0);
        a_start = 1'b1; step(); a_start = 1'b0;
        send(0, 8'h66, 0); step();
        send(0, 8'h77, 0); send(0, 8'h88, 1);
        step();
        check("gap_words", a_words, 11'd2);
        fetch_a("gap_w0", 32'h0, 32'h11223344);
        fetch_a("gap_w1", 32'h4, 32'h55667788);
        fetch_a("alias_hi", 32'h1000, 32'h11223344);
        fetch_a("alias_lo", 32'h7, 32'h55667788);

        // Reset after 6 bytes
        done_base = a_done_cnt;
        start(0);
        send(0, 8'h01, 0); send(0, 8'h02, 0); send(0, 8'h03, 0);
        send(0, 8'h04, 0); send(0, 8'h05, 0); send(0, 8'h06, 0);
        rst = 1'b1; step(); rst = 1'b0; step();
        check("midrst_busy",  a_busy, 1'b0);
        check("midrst_err",   a_err, 1'b0);
        check("midrst_words", a_words, 11'd0);
        check("midrst_done",  a_done_cnt - done_base, 0);
        fetch_a("midrst_w0", 32'h0, 32'h01020304);
        fetch_a("midrst_w1", 32'h4, 32'h55667788);
        start(0);
        send(0, 8'h0A, 0); send(0, 8'h0B, 0); send(0, 8'h0C, 0); send(0, 8'h0D, 1);
        step();
        check("reload_words", a_words, 11'd1);
        fetch_a("reload_w0", 32'h0, 32'h0A0B0C0D);
        fetch_a("reload_w1", 32'h4, 32'h55667788);

        // Overflow on a 4-word memory
        done_base = b_done_cnt;
        start(1);
        for (int i = 1; i <= 16; i++) send(1, 8'(i), 0);
        check("ovf_err_pre",   b_err, 1'b0);
        check("ovf_drain_rdy", b_ready, 1'b1);
        for (int i = 17; i <= 20; i++) send(1, 8'(i), i == 20);
        check("ovf_done",  b_done, 1'b1);
        step();
        check("ovf_err",   b_err, 1'b1);
        check("ovf_words", b_words, 3'd4);
        check("ovf_pulse", b_done_cnt - done_base, 1);
        b_ce = 1'b1;
        b_addr = 32'h0;  #1 check("ovf_w0", b_inst, 32'h01020304);
        b_addr = 32'h4;  #1 check("ovf_w1", b_inst, 32'h05060708);
        b_addr = 32'h8;  #1 check("ovf_w2", b_inst, 32'h090A0B0C);
        b_addr = 32'hC;  #1 check("ovf_w3", b_inst, 32'h0D0E0F10);
        b_addr = 32'h10; #1 check("ovf_alias", b_inst, 32'h01020304);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
